mod_updown_counter: RTL and testbench
=====================================

MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits; legal range 2..32.
REQ-002 Parameter PRESCALE_W, default 4: width of the prescale control.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 load  input  1  synchronous load strobe.
REQ-006 d_in  input  WIDTH  load value.
REQ-007 up_down  input  1  direction: 1 = up, 0 = down.
REQ-008 enable  input  1  count enable; feeds the prescaler.
REQ-009 mode  input  2  boundary mode: 0 = WRAP, 1 = SATURATE, 2 = ONESHOT, 3 = reserved (behaves as WRAP).
REQ-010 limit  input  WIDTH  upper bound; legal count range is 0..limit.
REQ-011 prescale  input  PRESCALE_W  count steps once per prescale+1 enabled cycles.
REQ-012 clr_flags  input  1  synchronous clear of ovf and unf.
REQ-013 count  output  WIDTH  registered counter value.
REQ-014 tc  output  1  registered terminal-count pulse, one cycle wide.
REQ-015 ovf  output  1  sticky overflow flag.
REQ-016 unf  output  1  sticky underflow flag.
REQ-017 halted  output  1  high while a ONESHOT run is stopped at a boundary.

Function
REQ-018 The prescaler counter increments on each cycle with enable=1 and load=0; when it equals prescale, tick asserts for that cycle and the prescaler returns to 0.
REQ-019 With enable=0, the prescaler and count hold their values; prescale=0 gives one tick per enabled cycle.
REQ-020 Priority per cycle: load > tick > hold.
REQ-021 Load sets count to min(d_in, limit), clears the prescaler and halted, and suppresses tc for that cycle.
REQ-022 On a tick with up=1 and count < limit, count increments by 1; on a tick with up=0 and count > 0, count decrements by 1.
REQ-023 Up boundary (count >= limit on a tick): WRAP sets count to 0; SATURATE holds count at limit; ONESHOT holds count and sets halted. Every mode sets ovf.
REQ-024 Down boundary (count == 0 on a tick): WRAP sets count to limit; SATURATE holds 0; ONESHOT holds count and sets halted. Every mode sets unf.
REQ-025 tc asserts in the cycle after any boundary tick (REQ-023/024) and only then; it does not assert while halted.
REQ-026 While halted=1, ticks do not change count, flags or tc; only load or reset clears halted.
REQ-027 limit may change at any time: count > limit with up=1 is treated as an up boundary on the next tick; with up=0 it decrements normally.
REQ-028 clr_flags clears ovf and unf; when a set and clr_flags occur in the same cycle, the set wins.
REQ-029 A change of mode or direction takes effect on the next tick without disturbing the prescaler.
REQ-030 All arithmetic is unsigned modulo 2^WIDTH; no internal value exceeds WIDTH bits except the prescaler (PRESCALE_W bits).

Reset
REQ-031 While rst_n=0: count=0, prescaler=0, tc=0, ovf=0, unf=0, halted=0, independent of clk.
REQ-032 Reset asserted mid-run abandons the run immediately; the first tick after release follows REQ-018 from prescaler=0.

Structure
REQ-033 The mode encoding is a typedef enum (MODE_WRAP, MODE_SAT, MODE_ONESHOT) in the shared package counter_pkg.
REQ-034 The prescaler is a separate sub-module, tick_prescaler (inputs: clk, rst_n, enable, clear, prescale; output: tick), which counter_pkg users may reuse.

Verification
REQ-035 WIDTH=8, limit=9, WRAP, up, prescale=0, enable held for 10 cycles from 0 -> count 1..9 then 0, tc pulses once after the wrap, ovf=1.
REQ-036 SATURATE, down, count=0, 3 ticks -> count stays 0, unf=1, tc pulses 3 times; clr_flags together with a 4th boundary tick -> unf stays 1.
REQ-037 ONESHOT, up, limit=5, start 3 -> count 4, 5, then halted=1 and count frozen at 5 for 5 further ticks; load d_in=2 -> count=2, halted=0.
REQ-038 prescale=3, enable continuous -> count advances once every 4 cycles; enable gated low for 2 cycles -> the step is delayed by exactly 2 cycles.
REQ-039 Load d_in=200 with limit=100 -> count=100; load in the same cycle as a boundary tick -> count=d_in, no tc, no flag change.
REQ-040 rst_n pulsed low mid-cycle during a run with ovf=1 -> all outputs 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types for the up/down counter family: boundary mode encoding
// and width limits used by counter and prescaler users.
package counter_pkg;

    // Boundary behaviour selected by the 2-bit mode input.
    // The reserved code is decoded exactly like MODE_WRAP.
    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    // Which boundary, if any, a tick ran into.
    typedef enum logic [1:0] {
        BND_NONE = 2'd0,
        BND_UP   = 2'd1,
        BND_DOWN = 2'd2
    } bnd_e;

    localparam int COUNTER_WIDTH_MIN = 2;
    localparam int COUNTER_WIDTH_MAX = 32;

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated prescaler: emits one tick per (prescale+1) enabled cycles.
// A clear restarts the count from zero and masks the tick for that cycle.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic                  hit;

    // Exact match: a prescale value lowered below the running count lets the
    // counter roll through its full range before the next tick.
    assign hit  = (cnt_q == prescale);
    assign tick = enable & ~clear & hit;

    // Next prescale count: clear dominates, otherwise advance only when enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = hit ? '0 : cnt_q + ONE;
        end
    end

    // Prescale count register, asynchronously reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Prescaled up/down counter with programmable upper limit, three boundary
// behaviours (wrap, saturate, one-shot), terminal-count pulse and sticky
// overflow/underflow flags.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      d_in,
    input  logic                  up_down,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  clr_flags,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  ovf,
    output logic                  unf,
    output logic                  halted
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             halted_q, halted_d;

    logic             tick;
    logic             step;
    mode_e            mode_s;
    bnd_e             bnd;
    logic [WIDTH-1:0] load_val;

    // Load also restarts the prescaler so the first tick after a load
    // arrives a full prescale period later.
    tick_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .clear    (load),
        .prescale (prescale),
        .tick     (tick)
    );

    assign mode_s   = mode_e'(mode);
    assign load_val = (d_in > limit) ? limit : d_in;

    // A halted one-shot run swallows ticks entirely.
    assign step = tick & ~halted_q;

    // Classify the tick: a count above limit while counting up is an up
    // boundary, while counting down it simply decrements.
    always_comb begin
        bnd = BND_NONE;
        if (step) begin
            if (up_down && (count_q >= limit)) begin
                bnd = BND_UP;
            end else if (!up_down && (count_q == '0)) begin
                bnd = BND_DOWN;
            end
        end
    end

    // Next count / halted / terminal count; load has priority over any tick.
    always_comb begin
        count_d  = count_q;
        halted_d = halted_q;
        tc_d     = 1'b0;
        if (load) begin
            count_d  = load_val;
            halted_d = 1'b0;
        end else if (step) begin
            case (bnd)
                BND_UP: begin
                    tc_d = 1'b1;
                    case (mode_s)
                        MODE_SAT:     count_d  = limit;
                        MODE_ONESHOT: halted_d = 1'b1;
                        default:      count_d  = '0;
                    endcase
                end
                BND_DOWN: begin
                    tc_d = 1'b1;
                    case (mode_s)
                        MODE_SAT:     count_d  = '0;
                        MODE_ONESHOT: halted_d = 1'b1;
                        default:      count_d  = limit;
                    endcase
                end
                default: begin
                    count_d = up_down ? count_q + ONE : count_q - ONE;
                end
            endcase
        end
    end

    // Sticky flags: a boundary in the same cycle as clr_flags keeps the flag set.
    always_comb begin
        ovf_d = (bnd == BND_UP)   | (ovf_q & ~clr_flags);
        unf_d = (bnd == BND_DOWN) | (unf_q & ~clr_flags);
    end

    // State registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            tc_q     <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            tc_q     <= tc_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            halted_q <= halted_d;
        end
    end

    assign count  = count_q;
    assign tc     = tc_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: directed vector table, hand-written corner
// sequences and a randomized run, all checked against a behavioural model.
module tb_mod_updown_counter;

    localparam int W  = 8;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          load = 1'b0;
    logic [W-1:0]  d_in = '0;
    logic          up_down = 1'b1;
    logic          enable = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [W-1:0]  limit = '0;
    logic [PW-1:0] prescale = '0;
    logic          clr_flags = 1'b0;
    logic [W-1:0]  count;
    logic          tc, ovf, unf, halted;

    int checks = 0;
    int failures = 0;

    // behavioural model state
    int m_cnt, m_pre;
    bit m_tc, m_ovf, m_unf, m_halt;

    typedef struct {
        bit ld; int din; bit up; bit en; int md; int lim; int pre; bit clr;
        int cnt; bit tc; bit ovf; bit unf; bit halt;
    } vec_t;
    vec_t tbl[$];

    mod_updown_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .d_in(d_in), .up_down(up_down),
        .enable(enable), .mode(mode), .limit(limit), .prescale(prescale),
        .clr_flags(clr_flags), .count(count), .tc(tc), .ovf(ovf), .unf(unf),
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_pre = 0; m_tc = 0; m_ovf = 0; m_unf = 0; m_halt = 0;
    endtask

    // One rising edge of the reference behaviour, from the pre-edge inputs.
    task automatic model_step();
        int lim;
        bit tk, nt, so, su;
        lim = int'(limit);
        tk = enable && !load && (m_pre == int'(prescale));
        nt = 0; so = 0; su = 0;
        if (load) m_pre = 0;
        else if (enable) m_pre = tk ? 0 : (m_pre + 1) % (1 << PW);
        if (load) begin
            m_cnt  = (int'(d_in) > lim) ? lim : int'(d_in);
            m_halt = 0;
        end else if (tk && !m_halt) begin
            if (up_down) begin
                if (m_cnt < lim) m_cnt = m_cnt + 1;
                else begin
                    so = 1; nt = 1;
                    if (mode == 2'd1) m_cnt = lim;
                    else if (mode == 2'd2) m_halt = 1;
                    else m_cnt = 0;
                end
            end else begin
                if (m_cnt > 0) m_cnt = m_cnt - 1;
                else begin
                    su = 1; nt = 1;
                    if (mode == 2'd1) m_cnt = 0;
                    else if (mode == 2'd2) m_halt = 1;
                    else m_cnt = lim;
                end
            end
        end
        m_tc  = nt;
        m_ovf = so | (m_ovf & !clr_flags);
        m_unf = su | (m_unf & !clr_flags);
    endtask

    // Advance one clock, update the model, compare at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model", {count, tc, ovf, unf, halted},
            {m_cnt[W-1:0], m_tc, m_ovf, m_unf, m_halt});
    endtask

    function automatic vec_t mk(bit ld, int din, bit up, bit en, int md, int lim, int pre,
                                bit clr, int cnt, bit t, bit o, bit u, bit h);
        vec_t v;
        v.ld = ld; v.din = din; v.up = up; v.en = en; v.md = md; v.lim = lim;
        v.pre = pre; v.clr = clr; v.cnt = cnt; v.tc = t; v.ovf = o; v.unf = u; v.halt = h;
        return v;
    endfunction

    initial begin
        int n;
        logic [W-1:0] prev;

        // asynchronous reset with no clock edge involved
        #1 rst_n = 1'b0;
        #1 chk("reset_state", {count, tc, ovf, unf, halted}, '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- directed vector table ----------------
        for (int k = 1; k <= 9; k++) tbl.push_back(mk(0,0,1,1,0,9,0,0, k,0,0,0,0));
        tbl.push_back(mk(0,0,1,1,0,9,0,0,   0,1,1,0,0));   // wrap after 9
        tbl.push_back(mk(0,0,1,0,0,9,0,0,   0,0,1,0,0));   // tc single pulse
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0,0,0,1,1,9,0,0, 0,1,1,1,0));
        tbl.push_back(mk(0,0,0,1,1,9,0,1,   0,1,0,1,0));   // set beats clear
        tbl.push_back(mk(0,0,0,0,1,9,0,1,   0,0,0,0,0));
        tbl.push_back(mk(1,200,1,1,0,100,0,0, 100,0,0,0,0)); // load clamps
        tbl.push_back(mk(1,7,1,1,0,100,0,0,   7,0,0,0,0));   // load beats boundary
        tbl.push_back(mk(0,0,1,0,0,100,0,0,   7,0,0,0,0));
        tbl.push_back(mk(1,50,1,1,0,100,0,0,  50,0,0,0,0));
        tbl.push_back(mk(0,0,0,1,0,20,0,0,    49,0,0,0,0));  // above limit, down
        tbl.push_back(mk(0,0,1,1,0,20,0,0,    0,1,1,0,0));   // above limit, up
        tbl.push_back(mk(0,0,1,0,0,20,0,0,    0,0,1,0,0));
        tbl.push_back(mk(0,0,1,0,0,20,0,1,    0,0,0,0,0));

        foreach (tbl[i]) begin
            load = tbl[i].ld; d_in = W'(tbl[i].din); up_down = tbl[i].up;
            enable = tbl[i].en; mode = 2'(tbl[i].md); limit = W'(tbl[i].lim);
            prescale = PW'(tbl[i].pre); clr_flags = tbl[i].clr;
            cycle();
            chk($sformatf("vec%0d", i), {count, tc, ovf, unf, halted},
                {W'(tbl[i].cnt), tbl[i].tc, tbl[i].ovf, tbl[i].unf, tbl[i].halt});
        end
        load = 0; clr_flags = 0;

        // ---------------- one-shot run ----------------
        load = 1; d_in = 3; limit = 5; mode = 2; up_down = 1; enable = 1; prescale = 0;
        cycle();
        load = 0;
        cycle(); chk("os_4", count, 4);
        cycle(); chk("os_5", {count, halted}, {8'd5, 1'b0});
        cycle(); chk("os_halt", {count, halted, tc}, {8'd5, 1'b1, 1'b1});
        for (int k = 0; k < 5; k++) begin
            cycle(); chk("os_frozen", {count, halted, tc}, {8'd5, 1'b1, 1'b0});
        end
        load = 1; d_in = 2;
        cycle(); chk("os_reload", {count, halted}, {8'd2, 1'b0});
        load = 0;

        // ---------------- prescale period and enable gating ----------------
        load = 1; d_in = 0; limit = 200; mode = 0; up_down = 1; prescale = 3; enable = 1;
        cycle();
        load = 0;
        for (int s = 0; s < 3; s++) begin
            prev = count; n = 0;
            do begin cycle(); n++; end while (count == prev && n < 20);
            chk("pre_period", n, 4);
        end
        prev = count;
        cycle();
        enable = 0; cycle(); cycle();
        enable = 1; n = 3;
        while (count == prev && n < 20) begin cycle(); n++; end
        chk("pre_gated", n, 6);

        // ---------------- asynchronous reset mid-run ----------------
        limit = 3; prescale = 0; mode = 0; up_down = 1; enable = 1;
        n = 0;
        while (!ovf && n < 20) begin cycle(); n++; end
        chk("ovf_before_rst", ovf, 1);
        #2 rst_n = 1'b0;
        #1 chk("async_rst", {count, tc, ovf, unf, halted}, '0);
        model_reset();
        @(negedge clk);
        chk("rst_held", {count, tc, ovf, unf, halted}, '0);
        prescale = 3;
        rst_n = 1'b1;
        n = 0;
        do begin cycle(); n++; end while (count == 0 && n < 20);
        chk("post_rst_first_tick", {n[7:0], count}, {8'd4, 8'd1});

        // ---------------- randomized run ----------------
        for (int r = 0; r < 800; r++) begin
            load = ($urandom % 16) == 0;
            d_in = W'($urandom);
            if ($urandom % 8 == 0) up_down = 1'($urandom);
            enable = ($urandom % 4) != 0;
            if ($urandom % 32 == 0) mode = 2'($urandom);
            if ($urandom % 20 == 0) limit = ($urandom % 2) ? W'($urandom % 12) : W'($urandom);
            if ($urandom % 40 == 0) prescale = PW'($urandom % 4);
            clr_flags = ($urandom % 16) == 0;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
